// File: rtl/linebuf_sched.sv
// Line-buffer / shift-register scheduler for the kernel filter path: primes, runs and drains the window.
// Optional statistics (frame_cnt, overrun) are built when LB_STATS_EN is defined; otherwise both are tied to 0.
module linebuf_sched #(
    parameter int CW      = 13,
    parameter int COL_MAX = 640,
    parameter int ROW_MAX = 480,
    parameter int X_TOTAL = 782,
    parameter int Y_LIMIT = 528,
    parameter int KERNEL  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          frame_start,
    input  logic [CW-1:0] row,
    input  logic [CW-1:0] col,
    input  logic [CW-1:0] x_count,
    input  logic [CW-1:0] y_count,
    output logic          wr_en,
    output logic [9:0]    wr_addr,
    output logic          shift_en,
    output logic          window_valid,
    output logic [9:0]    line_cnt,
    output logic [1:0]    state,
    output logic [15:0]   frame_cnt,
    output logic          overrun
);

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

    localparam logic [9:0]    PRIME_LINES = 10'(KERNEL - 1);
    localparam logic [9:0]    RUN_LINES   = 10'(ROW_MAX);
    localparam logic [9:0]    TOTAL_LINES = 10'(ROW_MAX + KERNEL / 2);
    localparam logic [CW-1:0] X_LAST      = CW'(X_TOTAL - 1);
    localparam logic [CW-1:0] Y_LIM       = CW'(Y_LIMIT);
    localparam logic [CW-1:0] COL_LIM     = CW'(COL_MAX);

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v >= TOTAL_LINES) ? TOTAL_LINES : v + 10'd1;
    endfunction

    state_t     state_q, state_d;
    logic       line_end, active_col, in_frame, abort, shift, done;
    logic [9:0] line_nxt;
    logic       wr_en_d, shift_en_d, wv_d;
    logic [9:0] wr_addr_d, line_cnt_d;
    logic       unused_inputs;

    assign unused_inputs = ^row;

    assign line_end   = (x_count == X_LAST) && (y_count < Y_LIM);
    assign active_col = (col < COL_LIM);
    assign in_frame   = (state_q != IDLE);
    assign abort      = in_frame && frame_start;
    // frame_start outranks a coincident line end, so the aborted line never shifts
    assign shift      = in_frame && line_end && !frame_start;
    assign line_nxt   = sat_inc(line_cnt);
    assign done       = shift && (state_q == DRAIN) && (line_nxt == TOTAL_LINES);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = enable ? PRIME : IDLE;
        end else if (shift) begin
            case (state_q)
                PRIME:   if (line_nxt == PRIME_LINES) state_d = RUN;
                RUN:     if (line_nxt == RUN_LINES)   state_d = DRAIN;
                DRAIN:   if (line_nxt == TOTAL_LINES) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        shift_en_d = 1'b0;
        wv_d       = 1'b0;
        line_cnt_d = line_cnt;
        if (frame_start && (enable || in_frame)) line_cnt_d = '0;
        else if (shift)                          line_cnt_d = line_nxt;
        if (!frame_start) begin
            shift_en_d = shift;
            case (state_q)
                PRIME, RUN: begin
                    wr_en_d   = active_col;
                    wr_addr_d = active_col ? col[9:0] : 10'd0;
                    wv_d      = (state_q == RUN) && active_col;
                end
                DRAIN:   wv_d = active_col;
                default: wv_d = 1'b0;
            endcase
        end
    end

    // Output register stage: everything lags the sampled timing inputs by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            shift_en     <= 1'b0;
            window_valid <= 1'b0;
            line_cnt     <= '0;
        end else begin
            wr_en        <= wr_en_d;
            wr_addr      <= wr_addr_d;
            shift_en     <= shift_en_d;
            window_valid <= wv_d;
            line_cnt     <= line_cnt_d;
        end
    end

    assign state = state_q;

`ifdef LB_STATS_EN
    logic [15:0] frame_cnt_q;
    logic        overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (done)  frame_cnt_q <= frame_cnt_q + 16'd1;
            if (abort) overrun_q   <= 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;
`else
    logic unused_stats;
    assign unused_stats = done | abort;
    assign frame_cnt    = '0;
    assign overrun      = 1'b0;
`endif

endmodule
